mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter onto a multiplexed 8-bit external bus. Each transaction is
// an address-high latch, an address-low latch, then one or two write bytes or two read bytes.
module mem_bus_arbiter #(
   parameter bit          FIXED_PRIO = 1'b0,
   parameter int unsigned RD_WAIT    = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic        r0_rreq,
   input  logic [15:1] r0_raddr,
   output logic [15:0] r0_rdata,
   output logic        r0_rdone,
   input  logic [15:1] r0_waddr,
   input  logic [1:0]  r0_wmask,
   input  logic [15:0] r0_wdata,
   output logic        r0_wdone,
   input  logic        r1_rreq,
   input  logic [15:1] r1_raddr,
   output logic [15:0] r1_rdata,
   output logic        r1_rdone,
   input  logic [15:1] r1_waddr,
   input  logic [1:0]  r1_wmask,
   input  logic [15:0] r1_wdata,
   output logic        r1_wdone,
   output logic [7:0]  bus_out,
   input  logic [7:0]  bus_in,
   output logic        latch_hi,
   output logic        latch_lo,
   output logic        wr,
   output logic        ind,
   output logic [1:0]  gnt
);

   typedef enum logic [3:0] {IDLE, AHI, ALO, WB0, WB1, RWAIT, RB0, RB1, DONE} state_t;

   localparam logic [2:0] WAIT_M1 = (RD_WAIT > 0) ? 3'(RD_WAIT - 1) : 3'd0;

   state_t      state_q;
   logic        sel_q, last_q, op_wr_q;
   logic [15:1] addr_q;
   logic [1:0]  mask_q;
   logic [15:0] wdata_q, rdata_q;
   logic [2:0]  wait_q;
   logic [7:0]  bus_out_q;
   logic        latch_hi_q, latch_lo_q, wr_q, ind_q;
   logic [1:0]  gnt_q;
   logic [3:0]  done_q;  // {r1_wdone, r1_rdone, r0_wdone, r0_rdone}

   logic        r0_req, r1_req, sel_d, op_wr_d;
   logic [15:1] addr_d;
   logic [1:0]  mask_d;
   logic [15:0] wdata_d;

   assign r0_req = r0_rreq | (|r0_wmask);
   assign r1_req = r1_rreq | (|r1_wmask);

   // Round-robin favours whichever requester did not finish the previous transaction.
   always_comb begin
      sel_d = r1_req;
      if (r0_req && r1_req) sel_d = FIXED_PRIO ? 1'b0 : ~last_q;
      if (sel_d) begin
         op_wr_d = |r1_wmask;
         addr_d  = op_wr_d ? r1_waddr : r1_raddr;
         mask_d  = r1_wmask;
         wdata_d = r1_wdata;
      end else begin
         op_wr_d = |r0_wmask;
         addr_d  = op_wr_d ? r0_waddr : r0_raddr;
         mask_d  = r0_wmask;
         wdata_d = r0_wdata;
      end
   end

   function automatic logic [3:0] done_vec(input logic sel, input logic is_wr);
      return 4'b0001 << {sel, is_wr};
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sel_q      <= 1'b0;
         last_q     <= 1'b1;
         op_wr_q    <= 1'b0;
         addr_q     <= '0;
         mask_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         wait_q     <= '0;
         bus_out_q  <= '0;
         latch_hi_q <= 1'b0;
         latch_lo_q <= 1'b0;
         wr_q       <= 1'b0;
         ind_q      <= 1'b0;
         gnt_q      <= '0;
         done_q     <= '0;
      end else if (ena) begin
         // NOTE: strobes and done default low here, so each lasts exactly one enabled cycle.
         bus_out_q  <= '0;
         latch_hi_q <= 1'b0;
         latch_lo_q <= 1'b0;
         wr_q       <= 1'b0;
         ind_q      <= 1'b0;
         done_q     <= '0;
         case (state_q)
            IDLE: if (r0_req || r1_req) begin
               state_q    <= AHI;
               sel_q      <= sel_d;
               op_wr_q    <= op_wr_d;
               addr_q     <= addr_d;
               mask_q     <= mask_d;
               wdata_q    <= wdata_d;
               gnt_q      <= sel_d ? 2'b10 : 2'b01;
               bus_out_q  <= addr_d[15:8];
               latch_hi_q <= 1'b1;
            end
            AHI: begin
               state_q    <= ALO;
               bus_out_q  <= {addr_q[7:1], 1'b0};
               latch_lo_q <= 1'b1;
               ind_q      <= op_wr_q & ~mask_q[0];
            end
            ALO: begin
               if (op_wr_q) begin
                  state_q   <= WB0;
                  bus_out_q <= mask_q[0] ? wdata_q[7:0] : wdata_q[15:8];
                  wr_q      <= 1'b1;
               end else if (RD_WAIT > 0) begin
                  state_q <= RWAIT;
                  wait_q  <= WAIT_M1;
               end else begin
                  state_q <= RB0;
               end
            end
            WB0: begin
               if (mask_q == 2'b11) begin
                  state_q   <= WB1;
                  bus_out_q <= wdata_q[15:8];
                  wr_q      <= 1'b1;
                  ind_q     <= 1'b1;
               end else begin
                  state_q <= DONE;
                  done_q  <= done_vec(sel_q, op_wr_q);
               end
            end
            WB1: begin
               state_q <= DONE;
               done_q  <= done_vec(sel_q, op_wr_q);
            end
            RWAIT: begin
               if (wait_q == 3'd0) state_q <= RB0;
               else                wait_q  <= wait_q - 3'd1;
            end
            RB0: begin
               state_q      <= RB1;
               rdata_q[7:0] <= bus_in;
               ind_q        <= 1'b1;
            end
            RB1: begin
               state_q       <= DONE;
               rdata_q[15:8] <= bus_in;
               done_q        <= done_vec(sel_q, op_wr_q);
            end
            DONE: begin
               state_q <= IDLE;
               gnt_q   <= '0;
               last_q  <= sel_q;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign r0_rdata = rdata_q;
   assign r1_rdata = rdata_q;
   assign r0_rdone = done_q[0];
   assign r0_wdone = done_q[1];
   assign r1_rdone = done_q[2];
   assign r1_wdone = done_q[3];
   assign bus_out  = bus_out_q;
   assign latch_hi = latch_hi_q;
   assign latch_lo = latch_lo_q;
   assign wr       = wr_q;
   assign ind      = ind_q;
   assign gnt      = gnt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a round-robin instance with RD_WAIT=2 carries the vector
// table; a fixed-priority instance with RD_WAIT=0 is checked for reset and starvation.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

   localparam int TB_RD_WAIT = 2;

   typedef struct packed {
      logic        rreq;
      logic [15:1] raddr;
      logic [15:1] waddr;
      logic [1:0]  wmask;
      logic [15:0] wdata;
   } req_t;

   typedef struct packed {
      logic [1:0] gnt;
      logic [7:0] bus;
      logic       lh;
      logic       ll;
      logic       wr;
      logic       ind;
      logic [3:0] done;
   } beat_t;

   typedef struct {
      beat_t       b;
      logic        chk_rd;
      logic [15:0] rd;
   } exp_beat_t;

   typedef struct {
      req_t        r0;
      req_t        r1;
      logic [7:0]  rd_lo;
      logic [7:0]  rd_hi;
      int          ena_at;
      logic [1:0]  x_gnt;
      logic        x_wr;
      logic [7:0]  x_ahi;
      logic [7:0]  x_alo;
      logic        x_alo_ind;
      logic [7:0]  x_d0;
      logic [7:0]  x_d1;
      int          x_nb;
      int          x_lat;
      logic [15:0] x_rdata;
   } vec_t;

   logic        clk, rst_n, ena;
   logic        r0_rreq, r1_rreq;
   logic [15:1] r0_raddr, r0_waddr, r1_raddr, r1_waddr;
   logic [1:0]  r0_wmask, r1_wmask;
   logic [15:0] r0_wdata, r1_wdata;
   logic [7:0]  rd_lo, rd_hi;

   logic [15:0] r0_rdata, r1_rdata;
   logic        r0_rdone, r0_wdone, r1_rdone, r1_wdone;
   logic [7:0]  bus_out, bus_in;
   logic        latch_hi, latch_lo, wr, ind;
   logic [1:0]  gnt;

   logic [15:0] fp_r0_rdata, fp_r1_rdata;
   logic        fp_r0_rdone, fp_r0_wdone, fp_r1_rdone, fp_r1_wdone;
   logic [7:0]  fp_bus_out, fp_bus_in;
   logic        fp_latch_hi, fp_latch_lo, fp_wr, fp_ind;
   logic [1:0]  fp_gnt;

   // External memory model: returns the even or odd byte according to ind.
   assign bus_in    = ind ? rd_hi : rd_lo;
   assign fp_bus_in = fp_ind ? rd_hi : rd_lo;

   wire [3:0] done_main = {r1_wdone, r1_rdone, r0_wdone, r0_rdone};
   wire [3:0] done_fp   = {fp_r1_wdone, fp_r1_rdone, fp_r0_wdone, fp_r0_rdone};

   mem_bus_arbiter #(.FIXED_PRIO(1'b0), .RD_WAIT(TB_RD_WAIT)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .r0_rreq(r0_rreq), .r0_raddr(r0_raddr), .r0_rdata(r0_rdata), .r0_rdone(r0_rdone),
      .r0_waddr(r0_waddr), .r0_wmask(r0_wmask), .r0_wdata(r0_wdata), .r0_wdone(r0_wdone),
      .r1_rreq(r1_rreq), .r1_raddr(r1_raddr), .r1_rdata(r1_rdata), .r1_rdone(r1_rdone),
      .r1_waddr(r1_waddr), .r1_wmask(r1_wmask), .r1_wdata(r1_wdata), .r1_wdone(r1_wdone),
      .bus_out(bus_out), .bus_in(bus_in), .latch_hi(latch_hi), .latch_lo(latch_lo),
      .wr(wr), .ind(ind), .gnt(gnt)
   );

   mem_bus_arbiter #(.FIXED_PRIO(1'b1), .RD_WAIT(0)) dut_fp (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .r0_rreq(r0_rreq), .r0_raddr(r0_raddr), .r0_rdata(fp_r0_rdata), .r0_rdone(fp_r0_rdone),
      .r0_waddr(r0_waddr), .r0_wmask(r0_wmask), .r0_wdata(r0_wdata), .r0_wdone(fp_r0_wdone),
      .r1_rreq(r1_rreq), .r1_raddr(r1_raddr), .r1_rdata(fp_r1_rdata), .r1_rdone(fp_r1_rdone),
      .r1_waddr(r1_waddr), .r1_wmask(r1_wmask), .r1_wdata(r1_wdata), .r1_wdone(fp_r1_wdone),
      .bus_out(fp_bus_out), .bus_in(fp_bus_in), .latch_hi(fp_latch_hi), .latch_lo(fp_latch_lo),
      .wr(fp_wr), .ind(fp_ind), .gnt(fp_gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   bit          mon_en   = 1'b0;
   int          beat_no  = 0;
   exp_beat_t   sb_q[$];
   beat_t       act_b;
   exp_beat_t   mon_e;
   req_t        no_req;
   vec_t        vecs[8];
   logic [1:0]  g_main[$];
   logic [1:0]  g_fp[$];
   logic [1:0]  rr_exp[4] = '{2'b01, 2'b10, 2'b01, 2'b10};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic req_t mk(input logic rreq, input logic [15:0] ra, input logic [15:0] wa,
                               input logic [1:0] m, input logic [15:0] d);
      return '{rreq, ra[15:1], wa[15:1], m, d};
   endfunction

   function automatic beat_t mkb(input logic [1:0] g, input logic [7:0] bus, input logic lh,
                                 input logic ll, input logic w, input logic i, input logic [3:0] dn);
      return '{g, bus, lh, ll, w, i, dn};
   endfunction

   task automatic set_req(input req_t a, input req_t b);
      r0_rreq = a.rreq; r0_raddr = a.raddr; r0_waddr = a.waddr; r0_wmask = a.wmask; r0_wdata = a.wdata;
      r1_rreq = b.rreq; r1_raddr = b.raddr; r1_waddr = b.waddr; r1_wmask = b.wmask; r1_wdata = b.wdata;
   endtask

   // Scoreboard consumer: every bus cycle of a granted transaction pops one expected beat.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         act_b = '{gnt, bus_out, latch_hi, latch_lo, wr, ind, done_main};
         if (gnt != 2'b00) begin
            beat_no++;
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat%0d: actual %0h required none", beat_no, act_b);
            end else begin
               mon_e = sb_q.pop_front();
               check($sformatf("beat%0d", beat_no), act_b, mon_e.b);
               if (mon_e.chk_rd)
                  check($sformatf("rdata%0d", beat_no), gnt[1] ? r1_rdata : r0_rdata, mon_e.rd);
            end
         end else begin
            check("idle_no_done", done_main, 4'b0000);
         end
      end
   end

   // Scoreboard producer: expands a vector into its expected per-cycle bus beats.
   task automatic run_txn(input int idx, input vec_t v);
      exp_beat_t bl[$];
      exp_beat_t eb;
      int        cyc;
      bit        seen;
      eb.chk_rd = 1'b0;
      eb.rd     = '0;
      eb.b = mkb(v.x_gnt, v.x_ahi, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);        bl.push_back(eb);
      eb.b = mkb(v.x_gnt, v.x_alo, 1'b0, 1'b1, 1'b0, v.x_alo_ind, 4'b0000); bl.push_back(eb);
      if (v.x_wr) begin
         eb.b = mkb(v.x_gnt, v.x_d0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000); bl.push_back(eb);
         if (v.x_nb == 2) begin
            eb.b = mkb(v.x_gnt, v.x_d1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000); bl.push_back(eb);
         end
      end else begin
         for (int i = 0; i < TB_RD_WAIT; i++) begin
            eb.b = mkb(v.x_gnt, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000); bl.push_back(eb);
         end
         eb.b = mkb(v.x_gnt, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000); bl.push_back(eb);
         eb.b = mkb(v.x_gnt, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000); bl.push_back(eb);
      end
      if (v.x_gnt == 2'b01) eb.b = mkb(v.x_gnt, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, v.x_wr ? 4'b0010 : 4'b0001);
      else                  eb.b = mkb(v.x_gnt, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, v.x_wr ? 4'b1000 : 4'b0100);
      eb.chk_rd = ~v.x_wr;
      eb.rd     = v.x_rdata;
      bl.push_back(eb);
      if (v.ena_at > 0)
         for (int i = 0; i < 3; i++) bl.insert(v.ena_at, bl[v.ena_at-1]);
      foreach (bl[i]) sb_q.push_back(bl[i]);

      rd_lo = v.rd_lo;
      rd_hi = v.rd_hi;
      set_req(v.r0, v.r1);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (v.ena_at > 0 && cyc == v.ena_at)     ena = 1'b0;
         if (v.ena_at > 0 && cyc == v.ena_at + 3) ena = 1'b1;
         if (done_main != 4'b0000) seen = 1'b1;
      end
      ena = 1'b1;
      if (seen) begin
         check($sformatf("v%0d_latency", idx), cyc, v.x_lat);
      end else begin
         n_checks++;
         n_fail++;
         $display("FAIL v%0d_timeout: no done after %0d cycles, required %0d", idx, cyc, v.x_lat);
      end
      set_req(no_req, no_req);
      @(negedge clk);
      check($sformatf("v%0d_leftover_beats", idx), sb_q.size(), 0);
      sb_q.delete();
   endtask

   initial begin
      int  cyc;
      bit  seen;
      logic [1:0] pm, pf;

      no_req = mk(1'b0, 16'h0, 16'h0, 2'b00, 16'h0);
      vecs[0] = '{mk(1'b0, 16'h0, 16'h1234, 2'b11, 16'hBEEF), no_req, 8'h00, 8'h00, 0,
                  2'b01, 1'b1, 8'h12, 8'h34, 1'b0, 8'hEF, 8'hBE, 2, 5, 16'h0000};
      vecs[1] = '{no_req, mk(1'b1, 16'h8002, 16'h0, 2'b00, 16'h0), 8'h5A, 8'hC3, 0,
                  2'b10, 1'b0, 8'h80, 8'h02, 1'b0, 8'h00, 8'h00, 0, 7, 16'hC35A};
      vecs[2] = '{mk(1'b0, 16'h0, 16'h2000, 2'b10, 16'hAB00), no_req, 8'h00, 8'h00, 0,
                  2'b01, 1'b1, 8'h20, 8'h00, 1'b1, 8'hAB, 8'h00, 1, 4, 16'h0000};
      vecs[3] = '{mk(1'b1, 16'h0010, 16'h0, 2'b00, 16'h0), mk(1'b1, 16'h0600, 16'h7FFE, 2'b01, 16'h1177),
                  8'hEE, 8'hEE, 0, 2'b10, 1'b1, 8'h7F, 8'hFE, 1'b0, 8'h77, 8'h00, 1, 4, 16'h0000};
      vecs[4] = '{mk(1'b0, 16'h0, 16'hFFFE, 2'b11, 16'h0102), mk(1'b1, 16'h1110, 16'h0, 2'b00, 16'h0),
                  8'h00, 8'h00, 0, 2'b01, 1'b1, 8'hFF, 8'hFE, 1'b0, 8'h02, 8'h01, 2, 5, 16'h0000};
      vecs[5] = '{mk(1'b1, 16'hA5A4, 16'h0, 2'b00, 16'h0), no_req, 8'h66, 8'h99, 5,
                  2'b01, 1'b0, 8'hA5, 8'hA4, 1'b0, 8'h00, 8'h00, 0, 10, 16'h9966};
      vecs[6] = '{no_req, mk(1'b1, 16'h00FE, 16'h0, 2'b00, 16'h0), 8'h00, 8'hFF, 0,
                  2'b10, 1'b0, 8'h00, 8'hFE, 1'b0, 8'h00, 8'h00, 0, 7, 16'hFF00};
      vecs[7] = '{mk(1'b0, 16'h0, 16'h0000, 2'b01, 16'h3344), no_req, 8'h00, 8'h00, 0,
                  2'b01, 1'b1, 8'h00, 8'h00, 1'b0, 8'h44, 8'h00, 1, 4, 16'h0000};

      rst_n = 1'b0;
      ena   = 1'b1;
      rd_lo = 8'h00;
      rd_hi = 8'h00;
      set_req(no_req, no_req);
      repeat (3) @(negedge clk);
      check("reset_main", {gnt, bus_out, latch_hi, latch_lo, wr, ind, done_main, r0_rdata, r1_rdata}, '0);
      check("reset_fp", {fp_gnt, fp_bus_out, fp_latch_hi, fp_latch_lo, fp_wr, fp_ind, done_fp,
                         fp_r0_rdata, fp_r1_rdata}, '0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) run_txn(i, vecs[i]);

      // Abort an r0 write in WB0; r0 also finished last, so the tie after reset
      // goes to r0 only if reset restored last-grant to r1.
      mon_en = 1'b0;
      set_req(mk(1'b0, 16'h0, 16'h4444, 2'b11, 16'h5555), no_req);
      repeat (3) @(negedge clk);
      check("abort_wb0_wr", wr, 1'b1);
      check("abort_wb0_gnt", gnt, 2'b01);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_strobes", {wr, latch_hi, latch_lo, ind, bus_out}, '0);
      check("abort_gnt", gnt, 2'b00);
      check("abort_done", done_main, 4'b0000);
      rst_n = 1'b1;
      set_req(no_req, no_req);
      repeat (2) begin
         @(negedge clk);
         check("abort_no_done", done_main, 4'b0000);
      end
      set_req(mk(1'b0, 16'h0, 16'h0100, 2'b01, 16'h00A1), mk(1'b0, 16'h0, 16'h0200, 2'b01, 16'h00B2));
      @(negedge clk);
      check("tie_after_reset_gnt", gnt, 2'b01);
      check("tie_after_reset_fp_gnt", fp_gnt, 2'b01);
      cyc  = 1;
      seen = 1'b0;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (done_main != 4'b0000) seen = 1'b1;
      end
      check("tie_after_reset_done", done_main, 4'b0010);
      check("tie_after_reset_latency", cyc, 4);
      set_req(no_req, no_req);
      @(negedge clk);

      // Both requesters hold write requests: round-robin alternates, fixed priority starves r1.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      set_req(mk(1'b0, 16'h0, 16'h0300, 2'b01, 16'h0011), mk(1'b0, 16'h0, 16'h0400, 2'b01, 16'h0022));
      pm = 2'b00;
      pf = 2'b00;
      for (int c = 0; c < 60 && (g_main.size() < 4 || g_fp.size() < 4); c++) begin
         @(negedge clk);
         if (pm == 2'b00 && gnt != 2'b00 && g_main.size() < 4)  g_main.push_back(gnt);
         if (pf == 2'b00 && fp_gnt != 2'b00 && g_fp.size() < 4) g_fp.push_back(fp_gnt);
         pm = gnt;
         pf = fp_gnt;
      end
      check("rr_grant_count", g_main.size(), 4);
      check("fp_grant_count", g_fp.size(), 4);
      foreach (g_main[i]) check($sformatf("rr_grant%0d", i), g_main[i], rr_exp[i]);
      foreach (g_fp[i])   check($sformatf("fp_grant%0d", i), g_fp[i], 2'b01);
      set_req(no_req, no_req);
      repeat (8) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded 200000 ns");
      $fatal(1, "global timeout");
   end

endmodule
